pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Supervises one Gowin rPLL instance, e.g. the 25 MHz pixel/system PLL fed from the 100 MHz board clock.
- Runs on the board reference clock, never on the PLL output.
- Pulses the PLL RESET, waits for LOCK, requires lock to stay stable, then releases the synchronous active-low reset of the PLL-clocked logic.
- Re-sequences on lock loss or soft request; retries on timeout and latches a fault after repeated failures.

Parameters:
- RST_CYCLES, 16: cycles pll_reset_o is held high per attempt (min 1).
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (min 1).
- TIMEOUT_CYCLES, 100000: cycles allowed in WAIT_LOCK before the attempt fails.
- MAX_RETRIES, 3: consecutive failed attempts tolerated; the next failure enters FAULT.
- SYNC_STAGES, 2: flip-flop depth of the lock synchronizer (min 2).

Ports:
- clk  in  1  board reference clock (the PLL CLKIN source)
- resetn  in  1  reset, synchronous active-low
- pll_lock_i  in  1  PLL LOCK; asynchronous to clk
- soft_rst_i  in  1  one-cycle request to restart the sequence
- pll_reset_o  out  1  drives PLL RESET, active-high
- sys_resetn_o  out  1  reset for PLL-clocked logic, active-low; downstream re-synchronizes it
- locked_o  out  1  high only in RUN
- fault_o  out  1  high only in FAULT
- retry_cnt_o  out  2  failed attempts since last success, saturating at 3

Behaviour:
- Reset (resetn=0 at a clk edge) puts all registers in a defined state on the next edge:
  - state=PLL_RST, counters=0
  - pll_reset_o=1, sys_resetn_o=0, locked_o=0, fault_o=0, retry_cnt_o=0
- lock_s is pll_lock_i after SYNC_STAGES flops. All decisions use lock_s, so latency from pll_lock_i is SYNC_STAGES cycles.
- All outputs are registered. An output takes its new state's value on the same edge as the state transition.
- States and transitions:
  - PLL_RST: pll_reset_o=1, sys_resetn_o=0. Count RST_CYCLES cycles, then go to WAIT_LOCK and clear the counter.
  - WAIT_LOCK: pll_reset_o=0. If lock_s=1, go to STABLE with counter=0.
    - If the counter reaches TIMEOUT_CYCLES-1 without lock, the attempt fails:
    - retry_cnt < MAX_RETRIES: increment retry_cnt, go to PLL_RST.
    - otherwise: go to FAULT.
  - STABLE: counter increments while lock_s=1.
    - If lock_s=0, go back to WAIT_LOCK, counter=0. The timeout restarts and retry_cnt is unchanged.
    - When the counter reaches STABLE_CYCLES-1 with lock_s=1, go to RUN and clear retry_cnt.
  - RUN: sys_resetn_o=1, locked_o=1.
    - If lock_s=0, go to PLL_RST. sys_resetn_o=0 on that same edge. This is a lock loss; retry_cnt is not incremented.
  - FAULT: pll_reset_o=1, sys_resetn_o=0, fault_o=1. Exit only via resetn.
- soft_rst_i=1 in any state except FAULT forces PLL_RST on the next edge with counter=0 and retry_cnt unchanged. Priority order: resetn > soft_rst_i > lock/timeout events.
- Counter width is clog2(max(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES)+1). retry_cnt saturates at 3 and never wraps.
- resetn asserted mid-sequence abandons all progress. No glitch may appear on sys_resetn_o: it only changes on state transitions.

Optional Feature:
- Macro: PLL_LOSS_COUNT_EN.
- When defined, add output loss_cnt_o (8 bits).
  - Increments on each RUN→PLL_RST transition caused by lock loss (not soft_rst_i).
  - Saturates at 255; cleared only by resetn.
- When undefined, the port and its logic are absent.

Decomposition:
- Package pll_seq_pkg holds:
  - state enum: PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT
  - retry/loss counter width constants
  - function computing the counter width
- One sub-module, pll_lock_sync: a SYNC_STAGES flop chain for pll_lock_i, reset to 0 by resetn.

Test Plan (RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=20, MAX_RETRIES=2, SYNC_STAGES=2):
1. Release resetn; raise pll_lock_i 10 cycles later and hold → pll_reset_o=1 for 4 cycles; sys_resetn_o and locked_o rise exactly 2+8 cycles after pll_lock_i rises; retry_cnt_o=0.
2. In STABLE, drop pll_lock_i for 1 cycle after 5 cycles → no release; STABLE count restarts; release 8 cycles after lock_s returns high.
3. In RUN, drop pll_lock_i → 2 cycles later sys_resetn_o=0 and pll_reset_o=1 for 4 cycles; relock gives RUN again; with PLL_LOSS_COUNT_EN, loss_cnt_o=1.
4. Keep pll_lock_i=0 → three PLL_RST pulses with retry_cnt_o=1 then 2; the third timeout gives fault_o=1, permanently; only resetn clears it.
5. Pulse soft_rst_i in RUN and in WAIT_LOCK → PLL_RST next edge; retry_cnt_o unchanged; loss_cnt_o unchanged.
6. Assert resetn low during STABLE with lock high → next edge: state PLL_RST, all outputs at reset values, retry_cnt_o=0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  localparam int unsigned RETRY_W = 2;
  localparam int unsigned LOSS_W  = 8;

  // Counter must hold the largest of the three phase lengths.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL LOCK into the clk domain.
module pll_lock_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Supervises an rPLL: reset pulse, lock wait, stability window, then releases sys reset.
// Optional lock-loss counter output enabled by defining PLL_LOSS_COUNT_EN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pll_lock_i,
  input  logic               soft_rst_i,
  output logic               pll_reset_o,
  output logic               sys_resetn_o,
  output logic               locked_o,
  output logic               fault_o,
  output logic [RETRY_W-1:0] retry_cnt_o
`ifdef PLL_LOSS_COUNT_EN
  ,
  output logic [LOSS_W-1:0]  loss_cnt_o
`endif
);

  localparam int unsigned CNT_W = cnt_width(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_reset_q, pll_reset_d;
  logic               sys_resetn_q, sys_resetn_d;
  logic               locked_q, locked_d;
  logic               fault_q, fault_d;
  logic               lock_s;

  pll_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk     (clk),
    .resetn  (resetn),
    .async_i (pll_lock_i),
    .sync_o  (lock_s)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_reset_q  <= 1'b1;
      sys_resetn_q <= 1'b0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_reset_q  <= pll_reset_d;
      sys_resetn_q <= sys_resetn_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
    end
  end

  // Next-state: soft restart outranks lock and timeout events.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (soft_rst_i && (state_q != FAULT)) begin
      state_d = PLL_RST;
      cnt_d   = '0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cnt_d = '0;
            if (32'(retry_q) < MAX_RETRIES) begin
              state_d = PLL_RST;
              retry_d = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
            end else begin
              state_d = FAULT;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
            state_d = RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d = PLL_RST;
            cnt_d   = '0;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs follow the next state so they change on the transition edge.
  always_comb begin
    pll_reset_d  = (state_d == PLL_RST) || (state_d == FAULT);
    sys_resetn_d = (state_d == RUN);
    locked_d     = (state_d == RUN);
    fault_d      = (state_d == FAULT);
  end

  assign pll_reset_o  = pll_reset_q;
  assign sys_resetn_o = sys_resetn_q;
  assign locked_o     = locked_q;
  assign fault_o      = fault_q;
  assign retry_cnt_o  = retry_q;

`ifdef PLL_LOSS_COUNT_EN
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              lock_loss_c;

  // Only a genuine lock drop in RUN counts; a soft restart does not.
  assign lock_loss_c = (state_q == RUN) && !soft_rst_i && !lock_s;

  always_comb begin
    loss_d = loss_q;
    if (lock_loss_c && (loss_q != '1)) loss_d = loss_q + LOSS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) loss_q <= '0;
    else         loss_q <= loss_d;
  end

  assign loss_cnt_o = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer against a phase/duration reference model.
module tb_pll_lock_sequencer;

  localparam int RST_C   = 4;
  localparam int STAB_C  = 8;
  localparam int TOUT_C  = 20;
  localparam int MAXR    = 2;
  localparam int SYNC_N  = 2;

  localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAULT = 4;

  logic       clk;
  logic       resetn;
  logic       pll_lock_i;
  logic       soft_rst_i;
  logic       pll_reset_o;
  logic       sys_resetn_o;
  logic       locked_o;
  logic       fault_o;
  logic [1:0] retry_cnt_o;
  logic [7:0] loss_v;
`ifdef PLL_LOSS_COUNT_EN
  logic [7:0] loss_cnt_o;
  assign loss_v = loss_cnt_o;
`else
  assign loss_v = 8'd0;
`endif

  logic [13:0] dut_v;
  assign dut_v = {pll_reset_o, sys_resetn_o, locked_o, fault_o, retry_cnt_o, loss_v};

  int vec_n = 0;
  int err_n = 0;
  int cyc   = 0;

  // Reference model: current phase, edge index the phase began, fail/loss tallies.
  int          m_phase = P_RST;
  int          m_enter = 0;
  int          m_fails = 0;
  int          m_losses = 0;
  logic [SYNC_N-1:0] m_sync = '0;

  pll_lock_sequencer #(
    .RST_CYCLES     (RST_C),
    .STABLE_CYCLES  (STAB_C),
    .TIMEOUT_CYCLES (TOUT_C),
    .MAX_RETRIES    (MAXR),
    .SYNC_STAGES    (SYNC_N)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pll_lock_i   (pll_lock_i),
    .soft_rst_i   (soft_rst_i),
    .pll_reset_o  (pll_reset_o),
    .sys_resetn_o (sys_resetn_o),
    .locked_o     (locked_o),
    .fault_o      (fault_o),
    .retry_cnt_o  (retry_cnt_o)
`ifdef PLL_LOSS_COUNT_EN
    ,
    .loss_cnt_o   (loss_cnt_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void go(input int p);
    m_phase = p;
    m_enter = cyc + 1;
  endfunction

  // One clock edge of the reference behaviour; n = edges spent in the phase incl. this one.
  function automatic void model_edge();
    int   n;
    logic ls;
    if (!resetn) begin
      m_phase  = P_RST;
      m_enter  = cyc + 1;
      m_fails  = 0;
      m_losses = 0;
      m_sync   = '0;
      return;
    end
    ls     = m_sync[SYNC_N-1];
    m_sync = {m_sync[SYNC_N-2:0], pll_lock_i};
    n      = cyc - m_enter + 1;
    if (soft_rst_i && m_phase != P_FAULT) begin
      go(P_RST);
      return;
    end
    case (m_phase)
      P_RST:  if (n >= RST_C) go(P_WAIT);
      P_WAIT: begin
        if (ls) go(P_STAB);
        else if (n >= TOUT_C) begin
          if (m_fails < MAXR) begin
            if (m_fails < 3) m_fails++;
            go(P_RST);
          end else go(P_FAULT);
        end
      end
      P_STAB: begin
        if (!ls) go(P_WAIT);
        else if (n >= STAB_C) begin
          m_fails = 0;
          go(P_RUN);
        end
      end
      P_RUN: begin
        if (!ls) begin
`ifdef PLL_LOSS_COUNT_EN
          if (m_losses < 255) m_losses++;
`endif
          go(P_RST);
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [13:0] exp_v();
    logic [7:0] l;
    l = 8'(m_losses);
    return {(m_phase == P_RST) || (m_phase == P_FAULT), m_phase == P_RUN,
            m_phase == P_RUN, m_phase == P_FAULT, 2'(m_fails), l};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; pll_lock_i = 1'b0; soft_rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); vec_n++;
      if (dut_v !== exp_v()) begin err_n++; $display("FAIL reset_model cyc=%0d dut=%h exp=%h", cyc, dut_v, exp_v()); end
    end
    vec_n++;
    if (dut_v !== 14'h2000) begin err_n++; $display("FAIL reset_values dut=%h exp=%h", dut_v, 14'h2000); end
  endtask

  task automatic test_bringup();
    int hi_n, rise_at;
    resetn = 1'b1;
    hi_n = (pll_reset_o === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step(); vec_n++;
      if (dut_v !== exp_v()) begin err_n++; $display("FAIL bringup_model cyc=%0d dut=%h exp=%h", cyc, dut_v, exp_v()); end
      if (pll_reset_o === 1'b1) hi_n++;
    end
    vec_n++;
    if (hi_n != RST_C) begin err_n++; $display("FAIL bringup_rst_len got=%0d exp=%0d", hi_n, RST_C); end
    pll_lock_i = 1'b1;
    rise_at = 0;
    for (int k = 1; k <= 30; k++) begin
      step(); vec_n++;
      if (dut_v !== exp_v()) begin err_n++; $display("FAIL bringup_model cyc=%0d dut=%h exp=%h", cyc, dut_v, exp_v()); end
      if (rise_at == 0 && sys_resetn_o === 1'b1) rise_at = k;
    end
    // Edges after the edge that first samples lock high.
    vec_n++;
    if (rise_at - 1 != SYNC_N + STAB_C) begin err_n++; $display("FAIL bringup_latency got=%0d exp=%0d", rise_at - 1, SYNC_N + STAB_C); end
    vec_n++;
    if ({locked_o, retry_cnt_o} !== 3'b100) begin err_n++; $display("FAIL bringup_run got=%b exp=100", {locked_o, retry_cnt_o}); end
  endtask

  task automatic test_stable_glitch();
    int rise_at;
    bit hit;
    soft_rst_i = 1'b1;
    step(); vec_n++;
    if (dut_v !== exp_v()) begin err_n++; $display("FAIL glitch_model cyc=%0d dut=%h exp=%h", cyc, dut_v, exp_v()); end
    soft_rst_i = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(); vec_n++;
      if (dut_v !== exp_v()) begin err_n++; $display("FAIL glitch_model cyc=%0d dut=%h exp=%h", cyc, dut_v, exp_v()); end
      hit = (m_phase == P_STAB);
    end
    vec_n++;
    if (!hit) begin err_n++; $display("FAIL glitch_reach_stable got=0 exp=1"); end
    for (int i = 0; i < 5; i++) begin
      step(); vec_n++;
      if (dut_v !== exp_v()) begin err_n++; $display("FAIL glitch_model cyc=%0d dut=%h exp=%h", cyc, dut_v, exp_v()); end
    end
    pll_lock_i = 1'b0;
    step();
    pll_lock_i = 1'b1;
    rise_at = 0;
    for (int k = 1; k <= 20; k++) begin
      step(); vec_n++;
      if (dut_v !== exp_v()) begin err_n++; $display("FAIL glitch_model cyc=%0d dut=%h exp=%h", cyc, dut_v, exp_v()); end
      if (rise_at == 0 && sys_resetn_o === 1'b1) rise_at = k;
    end
    vec_n++;
    if (rise_at - 1 != SYNC_N + STAB_C) begin err_n++; $display("FAIL glitch_release got=%0d exp=%0d", rise_at - 1, SYNC_N + STAB_C); end
  endtask

  task automatic test_lock_loss();
    int hi_n, first_hi;
    bit hit;
    pll_lock_i = 1'b0;
    hi_n = 0; first_hi = 0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 7) pll_lock_i = 1'b1;
      step(); vec_n++;
      if (dut_v !== exp_v()) begin err_n++; $display("FAIL loss_model cyc=%0d dut=%h exp=%h", cyc, dut_v, exp_v()); end
      if (k == 2) begin
        vec_n++;
        if (sys_resetn_o !== 1'b1) begin err_n++; $display("FAIL loss_early_drop got=%b exp=1", sys_resetn_o); end
      end
      if (pll_reset_o === 1'b1) begin
        hi_n++;
        if (first_hi == 0) first_hi = k;
      end
    end
    vec_n++;
    if (first_hi != SYNC_N + 1 || hi_n != RST_C) begin
      err_n++; $display("FAIL loss_rst_pulse got=%0d/%0d exp=%0d/%0d", first_hi, hi_n, SYNC_N + 1, RST_C);
    end
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(); vec_n++;
      if (dut_v !== exp_v()) begin err_n++; $display("FAIL loss_model cyc=%0d dut=%h exp=%h", cyc, dut_v, exp_v()); end
      hit = (locked_o === 1'b1);
    end
    vec_n++;
    if (!hit) begin err_n++; $display("FAIL loss_relock got=0 exp=1"); end
`ifdef PLL_LOSS_COUNT_EN
    vec_n++;
    if (loss_cnt_o !== 8'd1) begin err_n++; $display("FAIL loss_count got=%0d exp=1", loss_cnt_o); end
`endif
  endtask

  task automatic test_soft_rst();
    bit hit;
    soft_rst_i = 1'b1;
    step(); vec_n++;
    if ({pll_reset_o, locked_o, sys_resetn_o, retry_cnt_o} !== 5'b10000) begin
      err_n++; $display("FAIL soft_in_run got=%b exp=10000", {pll_reset_o, locked_o, sys_resetn_o, retry_cnt_o});
    end
    soft_rst_i = 1'b0;
    pll_lock_i = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 80 && !hit; i++) begin
      step(); vec_n++;
      if (dut_v !== exp_v()) begin err_n++; $display("FAIL soft_model cyc=%0d dut=%h exp=%h", cyc, dut_v, exp_v()); end
      hit = (retry_cnt_o === 2'd1) && (pll_reset_o === 1'b0);
    end
    vec_n++;
    if (!hit) begin err_n++; $display("FAIL soft_reach_wait got=0 exp=1"); end
    step();
    soft_rst_i = 1'b1;
    step(); vec_n++;
    if ({pll_reset_o, retry_cnt_o} !== 3'b101) begin
      err_n++; $display("FAIL soft_in_wait got=%b exp=101", {pll_reset_o, retry_cnt_o});
    end
    soft_rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(); vec_n++;
      if (dut_v !== exp_v()) begin err_n++; $display("FAIL soft_model cyc=%0d dut=%h exp=%h", cyc, dut_v, exp_v()); end
    end
  endtask

  task automatic test_fault();
    int first_f;
    resetn = 1'b0;
    step();
    resetn = 1'b1; pll_lock_i = 1'b0;
    first_f = 0;
    for (int k = 1; k <= 110; k++) begin
      soft_rst_i = (k == 90);
      if (k == 85) pll_lock_i = 1'b1;
      step(); vec_n++;
      if (dut_v !== exp_v()) begin err_n++; $display("FAIL fault_model cyc=%0d dut=%h exp=%h", cyc, dut_v, exp_v()); end
      if (first_f == 0 && fault_o === 1'b1) first_f = k;
      if (k == 24 || k == 48) begin
        vec_n++;
        if (retry_cnt_o !== 2'(k / 24)) begin err_n++; $display("FAIL fault_retry k=%0d got=%0d exp=%0d", k, retry_cnt_o, k / 24); end
      end
    end
    soft_rst_i = 1'b0;
    vec_n++;
    if (first_f != 3 * (RST_C + TOUT_C)) begin err_n++; $display("FAIL fault_entry got=%0d exp=%0d", first_f, 3 * (RST_C + TOUT_C)); end
    vec_n++;
    if ({fault_o, pll_reset_o, sys_resetn_o} !== 3'b110) begin
      err_n++; $display("FAIL fault_sticky got=%b exp=110", {fault_o, pll_reset_o, sys_resetn_o});
    end
    resetn = 1'b0;
    step(); vec_n++;
    if (dut_v !== 14'h2000) begin err_n++; $display("FAIL fault_clear dut=%h exp=%h", dut_v, 14'h2000); end
    resetn = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit hit;
    pll_lock_i = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step(); vec_n++;
      if (dut_v !== exp_v()) begin err_n++; $display("FAIL midrst_model cyc=%0d dut=%h exp=%h", cyc, dut_v, exp_v()); end
      hit = (m_phase == P_STAB);
    end
    step(); step();
    resetn = 1'b0;
    step(); vec_n++;
    if (dut_v !== 14'h2000) begin err_n++; $display("FAIL midrst_values dut=%h exp=%h", dut_v, 14'h2000); end
    resetn = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      resetn     = ($urandom_range(0, 399) != 0);
      soft_rst_i = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) pll_lock_i = ~pll_lock_i;
      step(); vec_n++;
      if (dut_v !== exp_v()) begin err_n++; $display("FAIL random_model cyc=%0d dut=%h exp=%h", cyc, dut_v, exp_v()); end
    end
    soft_rst_i = 1'b0;
    resetn     = 1'b1;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_stable_glitch();
    test_lock_loss();
    test_soft_rst();
    test_fault();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
